fetch_sequencer: RTL and testbench

- Sits directly downstream of the control unit and upstream of instruction/data memory.
- Owns the PC and the instruction register, and sequences instruction fetch, execute and data-memory access over the ihit/dhit handshake.
- Computes the next PC from the control unit's branch/jump decode and gates register-file writeback.
- Holds the halt state that stops the core.

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/execute/memory sequencer: owns the PC and instruction register and
// walks each instruction through FETCH, EXEC and optional MEM over ihit/dhit.
module fetch_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    input  logic        halt,
    input  logic        dren,
    input  logic        dwen,
    input  logic [1:0]  branch,
    input  logic [1:0]  jump,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        wb_en,
    output logic        halted
);

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalted} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        wb_en_q;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic        taken;
    logic [31:0] next_pc;

    assign pc_plus4_w = pc_q + 32'd4;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign taken      = ((branch == 2'b01) & zero) | ((branch == 2'b10) & ~zero);

    // Jump decode wins over any concurrent branch decode.
    always_comb begin
        next_pc = pc_plus4_w;
        if (jump == 2'b11) begin
            next_pc = {pc_plus4_w[31:28], jaddr, 2'b00};
        end else if (jump == 2'b01) begin
            next_pc = rs_data;
        end else if (taken) begin
            next_pc = pc_plus4_w + branch_off;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StFetch;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0;
            wb_en_q <= 1'b0;
        end else begin
            wb_en_q <= 1'b0;
            case (state_q)
                StFetch: begin
                    if (ihit) begin
                        instr_q <= imemload;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (halt) begin
                        state_q <= StHalted;
                    end else if (dren | dwen) begin
                        state_q <= StMem;
                    end else begin
                        pc_q    <= next_pc;
                        wb_en_q <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StMem: begin
                    if (dhit) begin
                        pc_q    <= next_pc;
                        wb_en_q <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StFetch;
            endcase
        end
    end

    // Gating with nRST keeps the fetch request low for the whole reset window.
    assign imemREN  = nRST & (state_q == StFetch);
    assign dmemREN  = (state_q == StMem) & dren;
    assign dmemWEN  = (state_q == StMem) & dwen;
    assign halted   = (state_q == StHalted);
    assign wb_en    = wb_en_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_w;
    assign instr    = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan steps followed by random
// instructions, checked against an arithmetic next-PC model.
module tb_fetch_sequencer;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic        halt;
    logic        dren;
    logic        dwen;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] rs_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        wb_en;
    logic        halted;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] pc_model;

    fetch_sequencer #(.PC_INIT(32'h0000_0000)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (ihit),
        .imemload (imemload),
        .dhit     (dhit),
        .halt     (halt),
        .dren     (dren),
        .dwen     (dwen),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .imm16    (imm16),
        .jaddr    (jaddr),
        .rs_data  (rs_data),
        .instr    (instr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .imemREN  (imemREN),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .wb_en    (wb_en),
        .halted   (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next PC computed directly from the decode rules with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] br,
                                               input logic [1:0] jp, input logic z,
                                               input logic [15:0] im, input logic [25:0] ja,
                                               input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        if (jp == 2'b11) return (p4 & 32'hF000_0000) | (32'(ja) * 32'd4);
        if (jp == 2'b01) return rs;
        if ((br == 2'b01 && z) || (br == 2'b10 && !z)) begin
            off = int'($signed(im)) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic apply_reset();
        nRST = 1'b0;
        ihit = 1'b0;
        dhit = 1'b0;
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_imemREN", 32'(imemREN), 32'd0);
        check("rst_dmem", {30'd0, dmemREN, dmemWEN}, 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        pc_model = 32'h0;
        #1;
        check("rst_release_imemREN", 32'(imemREN), 32'd1);
        @(negedge CLK);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves it in FETCH (or HALTED).
    task automatic do_instr(input int iw, input logic [31:0] word, input logic h,
                            input logic r, input logic w, input logic [1:0] br,
                            input logic [1:0] jp, input logic z, input logic [15:0] im,
                            input logic [25:0] ja, input logic [31:0] rs, input int dw);
        logic [31:0] exp_next;
        exp_next = model_next(pc_model, br, jp, z, im, ja, rs);
        halt = h; dren = r; dwen = w; branch = br; jump = jp; zero = z;
        imm16 = im; jaddr = ja; rs_data = rs;
        for (int i = 0; i < iw; i++) begin
            ihit = 1'b0;
            dhit = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check("fetch_wait_imemREN", 32'(imemREN), 32'd1);
            check("fetch_wait_pc", pc, pc_model);
        end
        ihit = 1'b1;
        imemload = word;
        dhit = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check("exec_instr", instr, word);
        check("exec_imemREN", 32'(imemREN), 32'd0);
        check("exec_wb_en", 32'(wb_en), 32'd0);
        check("exec_dmem", {30'd0, dmemREN, dmemWEN}, 32'd0);
        check("exec_pc", pc, pc_model);
        check("exec_pc_plus4", pc_plus4, pc_model + 32'd4);
        ihit = 1'($urandom_range(0, 1));
        imemload = $urandom;
        if (h) begin
            dhit = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_reqs", {29'd0, imemREN, dmemREN, dmemWEN}, 32'd0);
            check("halt_pc", pc, pc_model);
            return;
        end
        if (r | w) begin
            dhit = 1'b0;
            @(negedge CLK);
            for (int k = 0; k <= dw; k++) begin
                check("mem_dmemREN", 32'(dmemREN), 32'(r));
                check("mem_dmemWEN", 32'(dmemWEN), 32'(w));
                check("mem_imemREN", 32'(imemREN), 32'd0);
                check("mem_pc", pc, pc_model);
                check("mem_wb_en", 32'(wb_en), 32'd0);
                dhit = (k == dw);
                ihit = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
        end else begin
            dhit = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        pc_model = exp_next;
        check("done_pc", pc, pc_model);
        check("done_wb_en", 32'(wb_en), 32'd1);
        check("done_imemREN", 32'(imemREN), 32'd1);
        check("done_halted", 32'(halted), 32'd0);
        ihit = 1'b0;
        dhit = 1'b0;
    endtask

    initial begin
        nRST = 1'b1; ihit = 1'b0; imemload = '0; dhit = 1'b0; halt = 1'b0;
        dren = 1'b0; dwen = 1'b0; branch = '0; jump = '0; zero = 1'b0;
        imm16 = '0; jaddr = '0; rs_data = '0; pc_model = '0;
        #1;
        apply_reset();

        // ADDIU at reset PC
        do_instr(0, 32'h2401_0005, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0005, 26'h0, 32'h0, 0);
        check("addiu_pc", pc, 32'h4);
        // BEQ taken / not taken, BNE taken, all from pc=0x10
        do_instr(1, 32'h0000_0008, 0, 0, 0, 2'b00, 2'b01, 0, 16'h0, 26'h0, 32'h10, 0);
        do_instr(0, 32'h1000_FFFE, 0, 0, 0, 2'b01, 2'b00, 1, 16'hFFFE, 26'h0, 32'h0, 0);
        check("beq_taken_pc", pc, 32'h0C);
        do_instr(0, 32'h0000_0008, 0, 0, 0, 2'b00, 2'b01, 0, 16'h0, 26'h0, 32'h10, 0);
        do_instr(2, 32'h1000_FFFE, 0, 0, 0, 2'b01, 2'b00, 0, 16'hFFFE, 26'h0, 32'h0, 0);
        check("beq_not_taken_pc", pc, 32'h14);
        do_instr(0, 32'h0000_0008, 0, 0, 0, 2'b00, 2'b01, 0, 16'h0, 26'h0, 32'h10, 0);
        do_instr(0, 32'h1400_0003, 0, 0, 0, 2'b10, 2'b00, 0, 16'h0003, 26'h0, 32'h0, 0);
        check("bne_taken_pc", pc, 32'h20);
        // J keeps the upper nibble of pc+4
        do_instr(0, 32'h0000_0008, 0, 0, 0, 2'b00, 2'b01, 0, 16'h0, 26'h0, 32'hF000_0040, 0);
        do_instr(0, 32'h0800_0100, 0, 0, 0, 2'b00, 2'b11, 0, 16'h0, 26'h100, 32'h0, 0);
        check("j_pc", pc, 32'hF000_0400);
        // JR with a concurrent taken-looking BEQ
        do_instr(0, 32'h0000_0008, 0, 0, 0, 2'b01, 2'b01, 1, 16'h0010, 26'h0, 32'h1234, 0);
        check("jr_pc", pc, 32'h1234);
        // LW with three dhit-low MEM cycles
        do_instr(0, 32'h8C22_0000, 0, 1, 0, 2'b00, 2'b00, 0, 16'h0, 26'h0, 32'h0, 3);
        check("lw_pc", pc, 32'h1238);
        // Sequential wrap at the top of the address space
        do_instr(0, 32'h0000_0008, 0, 0, 0, 2'b00, 2'b01, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 0);
        do_instr(0, 32'h2401_0001, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        check("wrap_pc", pc, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] mem_sel;
            mem_sel = 2'($urandom_range(0, 3));
            do_instr(int'($urandom_range(0, 2)), $urandom, 1'b0,
                     (mem_sel == 2'd1) || (mem_sel == 2'd3 && n % 17 == 0),
                     (mem_sel == 2'd2) || (mem_sel == 2'd3 && n % 17 == 0),
                     2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                     26'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        // Reset while a load waits in MEM: request must drop with no clock edge
        ihit = 1'b1; imemload = 32'h8C01_0000; halt = 1'b0; dren = 1'b1; dwen = 1'b0;
        jump = 2'b00; branch = 2'b00;
        @(negedge CLK);
        ihit = 1'b0; dhit = 1'b0;
        @(negedge CLK);
        check("midmem_dmemREN_before", 32'(dmemREN), 32'd1);
        #3;
        nRST = 1'b0;
        #1;
        check("midmem_dmemREN_async", 32'(dmemREN), 32'd0);
        check("midmem_imemREN", 32'(imemREN), 32'd0);
        check("midmem_pc", pc, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        pc_model = 32'h0;
        #1;
        check("midmem_resume_imemREN", 32'(imemREN), 32'd1);
        @(negedge CLK);
        do_instr(1, 32'h2401_0002, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        check("midmem_after_pc", pc, 32'h4);

        // Halt wins over a concurrent load and is sticky
        do_instr(0, 32'h0000_000C, 1, 1, 0, 2'b00, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            ihit = 1'($urandom_range(0, 1));
            dhit = 1'($urandom_range(0, 1));
            imemload = $urandom;
            @(negedge CLK);
            check("halted_sticky", 32'(halted), 32'd1);
            check("halted_reqs", {29'd0, imemREN, dmemREN, dmemWEN}, 32'd0);
            check("halted_pc", pc, pc_model);
            check("halted_wb_en", 32'(wb_en), 32'd0);
        end
        apply_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
